// File: rtl/note_div_chord_if.sv
// Key/note bus for note_div_chord.
// master: key_valid, key_code, key_release, mode, octave_up (drives)
// slave : note_div, note_active, busy (drives)
interface note_div_chord_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 22
);
  logic                      key_valid;
  logic [6:0]                key_code;
  logic                      key_release;
  logic [1:0]                mode;
  logic                      octave_up;
  logic [NUM_CH*DIV_W-1:0]   note_div;
  logic                      note_active;
  logic                      busy;

  modport master (
    output key_valid, key_code, key_release, mode, octave_up,
    input  note_div, note_active, busy
  );

  modport slave (
    input  key_valid, key_code, key_release, mode, octave_up,
    output note_div, note_active, busy
  );
endinterface

// File: rtl/note_div_chord.sv
// Keyboard-driven chord divider generator.
// A legal key starts a LOOKUP that builds one channel divider per cycle into
// shadow registers, then commits all channels at once and plays the chord.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - note_div_chord_if.slave: key strobes/settings in, note_div,
//            note_active and busy out (all registered)
// Build option: NOTE_DIV_CHORD_HOLD_EN enables the post-release HOLD state
// with a HOLD_CYC-cycle counter; without it release silences on the next edge.
module note_div_chord #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DIV_W    = 22,
  parameter int unsigned HOLD_CYC = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  note_div_chord_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_CH + 1);
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [NUM_CH*DIV_W-1:0] SILENT = {NUM_CH{DIV_W'(1)}};

`ifdef NOTE_DIV_CHORD_HOLD_EN
  typedef enum logic [1:0] {IDLE, LOOKUP, PLAY, HOLD} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOOKUP, PLAY} state_e;
`endif

  state_e state_q, state_d;

  logic [3:0]                         step_q, step_d;
  logic [1:0]                         mode_q, mode_d;
  logic                               oct_q, oct_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_CH-1:0][DIV_W-1:0]       shadow_q, shadow_d;
  logic [NUM_CH*DIV_W-1:0]            note_div_q, note_div_d;
  logic                               active_q, active_d;
  logic                               busy_q, busy_d;
`ifdef NOTE_DIV_CHORD_HOLD_EN
  logic [HOLD_W-1:0]                  hold_cnt_q, hold_cnt_d;
`endif

  logic                               key_legal;
  logic [3:0]                         key_step;
  logic [5:0]                         offset;
  logic [5:0]                         sum;
  logic [3:0]                         ch_step;
  logic [DIV_W-1:0]                   ch_val;

  // ASCII key to {legal, step}
  function automatic logic [4:0] decode_key(input logic [6:0] code);
    case (code)
      7'd99:   return {1'b1, 4'd0};
      7'd100:  return {1'b1, 4'd1};
      7'd101:  return {1'b1, 4'd2};
      7'd102:  return {1'b1, 4'd3};
      7'd103:  return {1'b1, 4'd4};
      7'd97:   return {1'b1, 4'd5};
      7'd98:   return {1'b1, 4'd6};
      7'd67:   return {1'b1, 4'd7};
      7'd68:   return {1'b1, 4'd8};
      7'd69:   return {1'b1, 4'd9};
      7'd70:   return {1'b1, 4'd10};
      7'd71:   return {1'b1, 4'd11};
      7'd65:   return {1'b1, 4'd12};
      7'd66:   return {1'b1, 4'd13};
      default: return 5'd0;
    endcase
  endfunction

  // Step number to divider
  function automatic logic [17:0] step_div(input logic [3:0] s);
    case (s)
      4'd0:    return 18'd191571;
      4'd1:    return 18'd170648;
      4'd2:    return 18'd151515;
      4'd3:    return 18'd143266;
      4'd4:    return 18'd127551;
      4'd5:    return 18'd113636;
      4'd6:    return 18'd101215;
      4'd7:    return 18'd95420;
      4'd8:    return 18'd85034;
      4'd9:    return 18'd75758;
      4'd10:   return 18'd71633;
      4'd11:   return 18'd63775;
      4'd12:   return 18'd56818;
      4'd13:   return 18'd50607;
      4'd14:   return 18'd47755;
      default: return 18'd42553;
    endcase
  endfunction

  assign {key_legal, key_step} = decode_key(bus.key_code);

  // Divider for the channel selected by idx_q, from the latched key settings
  always_comb begin : chan_calc
    offset = '0;
    case (mode_q)
      2'b01:   offset = 6'(idx_q) << 1;
      2'b10:   offset = 6'(idx_q) * 6'd7;
      default: offset = '0;
    endcase
    sum     = {2'b00, step_q} + offset;
    ch_step = (sum > 6'd15) ? 4'd15 : sum[3:0];
    ch_val  = DIV_W'(step_div(ch_step));
    if (oct_q) ch_val = ch_val >> 1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; LOOKUP ignores key strobes until its commit cycle is done
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      LOOKUP: begin
        if (idx_q == IDX_W'(NUM_CH)) state_d = PLAY;
      end
      default: begin
        if (bus.key_valid) begin
          state_d = key_legal ? LOOKUP : IDLE;
        end else if (bus.key_release && state_q == PLAY) begin
`ifdef NOTE_DIV_CHORD_HOLD_EN
          state_d = HOLD;
`else
          state_d = IDLE;
`endif
        end
`ifdef NOTE_DIV_CHORD_HOLD_EN
        else if (state_q == HOLD && hold_cnt_q == '0) begin
          state_d = IDLE;
        end
`endif
      end
    endcase
  end

  // Datapath/output next values; idx_q == NUM_CH is the commit cycle
  always_comb begin : output_logic
    step_d     = step_q;
    mode_d     = mode_q;
    oct_d      = oct_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    note_div_d = note_div_q;
    active_d   = active_q;
`ifdef NOTE_DIV_CHORD_HOLD_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (state_q == LOOKUP) begin
      if (idx_q == IDX_W'(NUM_CH)) begin
        note_div_d = shadow_q;
        active_d   = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx_q == IDX_W'(i)) shadow_d[i] = ch_val;
        end
        idx_d = idx_q + 1'b1;
      end
    end else if (bus.key_valid) begin
      if (key_legal) begin
        step_d = key_step;
        mode_d = bus.mode;
        oct_d  = bus.octave_up;
        idx_d  = '0;
      end else begin
        note_div_d = SILENT;
        active_d   = 1'b0;
      end
    end else if (bus.key_release && state_q == PLAY) begin
`ifdef NOTE_DIV_CHORD_HOLD_EN
      hold_cnt_d = HOLD_W'(HOLD_CYC - 1);
`else
      note_div_d = SILENT;
      active_d   = 1'b0;
`endif
    end
`ifdef NOTE_DIV_CHORD_HOLD_EN
    else if (state_q == HOLD) begin
      if (hold_cnt_q == '0) begin
        note_div_d = SILENT;
        active_d   = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - 1'b1;
      end
    end
`endif
    busy_d = (state_d == LOOKUP) && (idx_d != IDX_W'(NUM_CH));
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      step_q     <= '0;
      mode_q     <= '0;
      oct_q      <= 1'b0;
      idx_q      <= '0;
      shadow_q   <= '0;
      note_div_q <= SILENT;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef NOTE_DIV_CHORD_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      step_q     <= step_d;
      mode_q     <= mode_d;
      oct_q      <= oct_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      note_div_q <= note_div_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
`ifdef NOTE_DIV_CHORD_HOLD_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign bus.note_div    = note_div_q;
  assign bus.note_active = active_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_note_div_chord.sv
module tb_note_div_chord;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [43:0] sb [$];
  int   tbl [16] = '{191571, 170648, 151515, 143266, 127551, 113636, 101215, 95420,
                     85034, 75758, 71633, 63775, 56818, 50607, 47755, 42553};
  localparam logic [43:0] SIL = {22'd1, 22'd1};

  note_div_chord_if #(.NUM_CH(2), .DIV_W(22)) bif ();

  note_div_chord #(.NUM_CH(2), .DIV_W(22), .HOLD_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int key_base(input logic [6:0] code);
    string keys;
    keys = "cdefgabCDEFGAB";
    for (int i = 0; i < 14; i++) begin
      if (keys[i] == {1'b0, code}) return i;
    end
    return -1;
  endfunction

  function automatic logic [21:0] model(input int base, input logic [1:0] md,
                                        input int ch, input bit oct);
    int s;
    int v;
    s = base;
    if (md == 2'b01) s = base + 2 * ch;
    if (md == 2'b10) s = base + 7 * ch;
    if (s > 15) s = 15;
    v = tbl[s];
    if (oct) v = v / 2;
    return 22'(v);
  endfunction

  // Strobe a legal key and follow the lookup to its commit
  task automatic press(input logic [6:0] code, input logic [1:0] md, input bit oct,
                       input bit rel, input bit poke);
    logic [43:0] prev;
    logic        prev_act;
    logic [43:0] e;
    int          b;
    prev     = bif.note_div;
    prev_act = bif.note_active;
    b        = key_base(code);
    sb.push_back({model(b, md, 1, oct), model(b, md, 0, oct)});
    bif.key_valid   = 1'b1;
    bif.key_code    = code;
    bif.mode        = md;
    bif.octave_up   = oct;
    bif.key_release = rel;
    tick();
    bif.key_valid   = poke;
    bif.key_code    = 7'd103;
    bif.key_release = poke;
    bif.mode        = ~md;
    bif.octave_up   = ~oct;
    chk("busy_c1", 64'(bif.busy), 64'd1);
    chk("div_c1", 64'(bif.note_div), 64'(prev));
    tick();
    bif.key_valid   = 1'b0;
    bif.key_release = 1'b0;
    chk("busy_c2", 64'(bif.busy), 64'd1);
    chk("act_c2", 64'(bif.note_active), 64'(prev_act));
    tick();
    chk("busy_c3", 64'(bif.busy), 64'd0);
    chk("div_c3", 64'(bif.note_div), 64'(prev));
    tick();
    e = sb.pop_front();
    chk("div_commit", 64'(bif.note_div), 64'(e));
    chk("act_commit", 64'(bif.note_active), 64'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bif.key_valid = 1'b0;
    bif.key_code = 7'd0;
    bif.key_release = 1'b0;
    bif.mode = 2'b00;
    bif.octave_up = 1'b0;
    tick();
    tick();
    chk("rst_div", 64'(bif.note_div), 64'(SIL));
    chk("rst_act", 64'(bif.note_active), 64'd0);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    rst_n = 1'b1;
    tick();

    press(7'd99, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("uni_ch0", 64'(bif.note_div[21:0]), 64'd191571);
    chk("uni_ch1", 64'(bif.note_div[43:22]), 64'd191571);

    press(7'd99, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("thirds_ch1", 64'(bif.note_div[43:22]), 64'd151515);

    press(7'd66, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("oct_ch0", 64'(bif.note_div[21:0]), 64'd50607);
    chk("oct_clamp", 64'(bif.note_div[43:22]), 64'd42553);

    press(7'd97, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("octup_ch0", 64'(bif.note_div[21:0]), 64'd56818);

    press(7'd70, 2'b11, 1'b0, 1'b0, 1'b0);

`ifdef NOTE_DIV_CHORD_HOLD_EN
    press(7'd99, 2'b00, 1'b0, 1'b0, 1'b0);
    bif.key_release = 1'b1;
    tick();
    bif.key_release = 1'b0;
    chk("hold_div0", 64'(bif.note_div), 64'({22'd191571, 22'd191571}));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("hold_div", 64'(bif.note_div), 64'({22'd191571, 22'd191571}));
      chk("hold_act", 64'(bif.note_active), 64'd1);
    end
    tick();
    chk("hold_end_div", 64'(bif.note_div), 64'(SIL));
    chk("hold_end_act", 64'(bif.note_active), 64'd0);

    press(7'd99, 2'b00, 1'b0, 1'b0, 1'b0);
    bif.key_release = 1'b1;
    tick();
    bif.key_release = 1'b0;
    tick();
    tick();
    press(7'd100, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("retrig", 64'(bif.note_div[21:0]), 64'd170648);
`else
    bif.key_release = 1'b1;
    tick();
    bif.key_release = 1'b0;
    chk("rel_div", 64'(bif.note_div), 64'(SIL));
    chk("rel_act", 64'(bif.note_active), 64'd0);
    press(7'd100, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("replay", 64'(bif.note_div[21:0]), 64'd170648);
`endif

    // Simultaneous key and release in PLAY: key wins
    press(7'd101, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("prio_ch0", 64'(bif.note_div[21:0]), 64'd151515);

    // Illegal key while playing silences
    bif.key_valid = 1'b1;
    bif.key_code  = 7'd120;
    tick();
    bif.key_valid = 1'b0;
    chk("illegal_div", 64'(bif.note_div), 64'(SIL));
    chk("illegal_act", 64'(bif.note_active), 64'd0);

    // Release in IDLE does nothing
    bif.key_release = 1'b1;
    tick();
    bif.key_release = 1'b0;
    tick();
    chk("idle_rel_div", 64'(bif.note_div), 64'(SIL));
    chk("idle_rel_busy", 64'(bif.busy), 64'd0);

    // Reset in the middle of a lookup
    press(7'd102, 2'b00, 1'b0, 1'b0, 1'b0);
    bif.key_valid = 1'b1;
    bif.key_code  = 7'd101;
    tick();
    bif.key_valid = 1'b0;
    chk("mid_busy", 64'(bif.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_div", 64'(bif.note_div), 64'(SIL));
    chk("mid_rst_act", 64'(bif.note_active), 64'd0);
    chk("mid_rst_busy", 64'(bif.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("no_commit_div", 64'(bif.note_div), 64'(SIL));
    chk("no_commit_act", 64'(bif.note_active), 64'd0);

    press(7'd103, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_div_chord.md
NOTE_DIV_CHORD -- requirements
Module: note_div_chord

Interface
- REQ-001 SHALL have parameters: NUM_CH, default 2, number of output channels (legal 1..4); DIV_W, default 22, divider width; HOLD_CYC, default 25000000, release-hold length in clk cycles (>=1).
- REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous active-low reset.
- REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_code.
- REQ-005 SHALL have port key_code  input  7  ASCII key: c,d,e,f,g,a,b (99,100,101,102,103,97,98) = steps 0..6; C,D,E,F,G,A,B (67,68,69,70,71,65,66) = steps 7..13.
- REQ-006 SHALL have port key_release  input  1  one-cycle strobe, key lifted.
- REQ-007 SHALL have port mode  input  2  00 unison, 01 thirds (channel i = step+2i), 10 octaves (channel i = step+7i), 11 treated as 00.
- REQ-008 SHALL have port octave_up  input  1  halve every divider (logical shift right 1).
- REQ-009 SHALL have port note_div  output  NUM_CH*DIV_W  channel i at bits [i*DIV_W +: DIV_W], registered.
- REQ-010 SHALL have port note_active  output  1  high while any tone is sounding.
- REQ-011 SHALL have port busy  output  1  high during LOOKUP.

Function
- REQ-012 SHALL use step table 0..15: 191571,170648,151515,143266,127551,113636,101215,95420,85034,75758,71633,63775,56818,50607,47755,42553.
- REQ-013 SHALL clamp any computed step above 15 to 15.
- REQ-014 SHALL output divider value 1 for a silent channel.
- REQ-015 SHALL implement FSM states IDLE, LOOKUP, PLAY, HOLD.
- REQ-016 SHALL, in IDLE/PLAY/HOLD on key_valid with a legal code, latch key_code, mode and octave_up and enter LOOKUP.
- REQ-017 SHALL, in LOOKUP, compute one channel per cycle into a shadow register, channel 0 first, and take NUM_CH cycles.
- REQ-018 SHALL commit all shadow registers to note_div simultaneously on the cycle after the last channel, set note_active, and enter PLAY; key_valid at edge t gives new note_div visible after edge t+NUM_CH+1.
- REQ-019 SHALL ignore key_valid and key_release while busy is high.
- REQ-020 SHALL, on key_valid with an illegal code outside LOOKUP, set all channels to 1, clear note_active and go to IDLE on the next edge.
- REQ-021 SHALL, in PLAY on key_release, enter HOLD, keep note_div unchanged, and load the hold counter with HOLD_CYC-1.
- REQ-022 SHALL, in HOLD, decrement the counter each cycle; at counter 0 set all channels to 1, clear note_active and go to IDLE.
- REQ-023 SHALL give key_valid priority over key_release when both are asserted in the same cycle.
- REQ-024 SHALL treat key_release in IDLE or HOLD as no-op.
- REQ-025 SHALL let mode and octave_up changes affect only the next LOOKUP, not the note currently playing.

Reset
- REQ-026 SHALL, on rst_n low at any time including mid-LOOKUP or HOLD, immediately force FSM to IDLE, every note_div channel to 1, note_active 0, busy 0, hold counter and shadow registers 0.
- REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
- REQ-028 SHALL use macro NOTE_DIV_CHORD_HOLD_EN: when defined, release behaves per REQ-021/022; when undefined, HOLD state and counter are removed and key_release in PLAY sets all channels to 1 and clears note_active on the next edge, going directly to IDLE.

Verification (NUM_CH=2, HOLD_CYC=8, NOTE_DIV_CHORD_HOLD_EN defined unless stated)
- REQ-029 SHALL cover reset: rst_n low -> note_div = {1,1}, note_active 0, busy 0.
- REQ-030 SHALL cover mode 00, key 99 strobe at edge t -> busy high for 2 cycles; both channels 191571 and note_active 1 after edge t+3.
- REQ-031 SHALL cover mode 01 with key 99 -> ch0 191571, ch1 151515; mode 10 with key 66 -> ch0 50607, ch1 42553 (clamped).
- REQ-032 SHALL cover octave_up 1, mode 00, key 97 -> both channels 56818.
- REQ-033 SHALL cover release in PLAY -> note_div held 8 cycles then {1,1}, note_active 0; key 100 during HOLD -> retrigger to 170648 with no silent cycle; with macro undefined -> {1,1} one edge after release.
- REQ-034 SHALL cover rst_n pulsed mid-LOOKUP -> outputs {1,1} immediately, no commit afterwards; simultaneous key_valid(101) and key_release in PLAY -> new note 151515 committed.
